// File: rtl/mips_dbg_pkg.sv
// Shared debug-path definitions for the MIPS run controller and the debug
// command decoder. Both sides use these state, command and stop-cause codes.
package mips_dbg_pkg;

  // Run-controller states; the encodings are exported on o_state for LEDs.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } run_state_e;

  // Commands issued by the debug command decoder.
  typedef enum logic [1:0] {
    CMD_STOP  = 2'd0,
    CMD_RUN   = 2'd1,
    CMD_STEP  = 2'd2,
    CMD_CLEAR = 2'd3
  } dbg_cmd_e;

  // Reason reported with each stop event.
  typedef enum logic [1:0] {
    CAUSE_CMD  = 2'd0,
    CAUSE_STEP = 2'd1,
    CAUSE_HALT = 2'd2,
    CAUSE_BP   = 2'd3
  } stop_cause_e;

endpackage

// File: rtl/dbg_cycle_counter.sv
// Enabled-cycle counter for the run controller.
// Ports:
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   i_enable         : count this cycle
//   i_clear          : synchronous clear, wins over i_enable
//   o_count          : current count, wraps modulo 2^WIDTH
module dbg_cycle_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_enable,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_enable) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;

endmodule

// File: rtl/mips_run_ctrl.sv
// Execution controller between the debug command decoder and the MIPS
// pipeline. Turns STOP/RUN/STEP/CLEAR commands into a pipeline clock enable,
// stops on breakpoint PC match, drains the pipeline after HALT, counts
// enabled cycles and reports each stop with a one-cycle event and a cause.
// Ports:
//   i_clk, i_reset_n          : clock, asynchronous active-low reset
//   i_cmd_valid/i_cmd         : command strobe and code
//   o_cmd_ready               : command accepted when valid & ready
//   i_dump_busy               : UART dump in progress, stalls commands
//   i_halt                    : HALT decoded in the pipeline (level)
//   i_mips_pc                 : current fetch PC
//   i_bp_enable/i_bp_addr     : breakpoint arm and address
//   o_mips_enable             : pipeline clock enable
//   o_cycle_count             : enabled cycles since reset/CLEAR
//   o_stop_event/o_stop_cause : stop pulse and held cause code
//   o_state                   : current state for debug LEDs
module mips_run_ctrl
  import mips_dbg_pkg::*;
#(
  parameter int unsigned BITS_SIZE    = 32,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_cmd_valid,
  input  logic [1:0]           i_cmd,
  output logic                 o_cmd_ready,
  input  logic                 i_dump_busy,
  input  logic                 i_halt,
  input  logic [BITS_SIZE-1:0] i_mips_pc,
  input  logic                 i_bp_enable,
  input  logic [BITS_SIZE-1:0] i_bp_addr,
  output logic                 o_mips_enable,
  output logic [BITS_SIZE-1:0] o_cycle_count,
  output logic                 o_stop_event,
  output logic [1:0]           o_stop_cause,
  output logic [2:0]           o_state
);

  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES - 1);

  run_state_e    state_q, state_d;
  logic [DW-1:0] drain_cnt_q, drain_cnt_d;
  logic          bp_skip_q, bp_skip_d;
  logic          stop_event_q, stop_event_d;
  stop_cause_e   stop_cause_q, stop_cause_d;

  dbg_cmd_e cmd;
  logic     cmd_accept;
  logic     bp_hit;
  logic     cnt_clear;

  assign cmd        = dbg_cmd_e'(i_cmd);
  assign cmd_accept = i_cmd_valid & o_cmd_ready;
  // bp_skip masks the match for the first RUN cycle after a resume so the
  // pipeline can step off the breakpoint address.
  assign bp_hit     = i_bp_enable & (i_mips_pc == i_bp_addr) & ~bp_skip_q;

  always_comb begin
    state_d       = state_q;
    drain_cnt_d   = drain_cnt_q;
    bp_skip_d     = bp_skip_q;
    stop_event_d  = 1'b0;
    stop_cause_d  = stop_cause_q;
    cnt_clear     = 1'b0;
    o_mips_enable = 1'b0;
    o_cmd_ready   = ~i_dump_busy &
                    ((state_q == ST_IDLE) | (state_q == ST_RUN) | (state_q == ST_HALTED));

    case (state_q)
      ST_IDLE: begin
        if (cmd_accept) begin
          case (cmd)
            CMD_RUN: begin
              state_d   = ST_RUN;
              bp_skip_d = 1'b1;
            end
            CMD_STEP:  state_d   = ST_STEP;
            CMD_CLEAR: cnt_clear = 1'b1;
            CMD_STOP:  ;
            default:   ;
          endcase
        end
      end
      ST_RUN: begin
        // Breakpoint drops the enable in the matching cycle itself.
        o_mips_enable = ~bp_hit;
        if (!bp_hit) bp_skip_d = 1'b0;
        if (bp_hit) begin
          state_d      = ST_IDLE;
          stop_event_d = 1'b1;
          stop_cause_d = CAUSE_BP;
        end else if (i_halt) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = DRAIN_INIT;
        end else if (cmd_accept) begin
          if (cmd == CMD_STOP) begin
            state_d      = ST_IDLE;
            stop_event_d = 1'b1;
            stop_cause_d = CAUSE_CMD;
          end else if (cmd == CMD_CLEAR) begin
            cnt_clear = 1'b1;
          end
        end
      end
      ST_STEP: begin
        o_mips_enable = 1'b1;
        if (i_halt) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = DRAIN_INIT;
        end else begin
          state_d      = ST_IDLE;
          stop_event_d = 1'b1;
          stop_cause_d = CAUSE_STEP;
        end
      end
      ST_DRAIN: begin
        o_mips_enable = 1'b1;
        if (drain_cnt_q == '0) begin
          state_d      = ST_HALTED;
          stop_event_d = 1'b1;
          stop_cause_d = CAUSE_HALT;
        end else begin
          drain_cnt_d = drain_cnt_q - DW'(1);
        end
      end
      ST_HALTED: begin
        if (cmd_accept && cmd == CMD_CLEAR) begin
          state_d   = ST_IDLE;
          cnt_clear = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= ST_IDLE;
      drain_cnt_q  <= '0;
      bp_skip_q    <= 1'b0;
      stop_event_q <= 1'b0;
      stop_cause_q <= CAUSE_CMD;
    end else begin
      state_q      <= state_d;
      drain_cnt_q  <= drain_cnt_d;
      bp_skip_q    <= bp_skip_d;
      stop_event_q <= stop_event_d;
      stop_cause_q <= stop_cause_d;
    end
  end

  dbg_cycle_counter #(
    .WIDTH (BITS_SIZE)
  ) u_cycle_counter (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_enable  (o_mips_enable),
    .i_clear   (cnt_clear),
    .o_count   (o_cycle_count)
  );

  assign o_stop_event = stop_event_q;
  assign o_stop_cause = stop_cause_q;
  assign o_state      = state_q;

endmodule
